// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and its pickers.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        CHECK      = 2'd2,
        WAIT_SPACE = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int IDX_W          = $clog2(DEF_NUM_REQ);

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at ptr, wrapping at N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        int cand;
        found = 1'b0;
        index = '0;
        cand  = 0;
        // Walk offsets from far to near so the closest hit to ptr is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                found = 1'b1;
                index = W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// retrying a rejected word once the FIFO reports space.
//
// state      | meaning
// IDLE       | waiting for a valid request while the FIFO is not full
// ISSUE      | wr_en high for one cycle with the latched word
// CHECK      | FIFO's registered wr_ack/overflow is valid this cycle
// WAIT_SPACE | write rejected; grant held until full drops
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int IW         = idx_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_ack,
    input  logic                          overflow,
    input  logic                          full,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          retry_cnt
);

    arb_state_t            state;
    logic [IW-1:0]         rr_ptr;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [FIFO_WIDTH-1:0] pick_data;
    logic [IW-1:0]         next_ptr;

    rr_pick #(
        .N (NUM_REQ),
        .W (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign pick_data = req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
    assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            data_q    <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !full) begin
                        grant_id <= pick_idx;
                        data_q   <= pick_data;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= CHECK;
                CHECK: begin
                    if (wr_ack) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        if (retry_cnt != '1) begin
                            retry_cnt <= retry_cnt + CNT_WIDTH'(1);
                        end
                        state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (!full) begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_ready is masked by rst so an abandoned grant never completes its handshake.
    always_comb begin
        req_ready = '0;
        if (state == CHECK && wr_ack && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign wr_en   = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign data_in = data_q;

    a_ack_ovf_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(state == CHECK && wr_ack && overflow));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural 8-deep FIFO, table of grant sequences, corner sequences.
module tb_fifo_wr_arbiter;
    localparam int NR   = 4;
    localparam int FW   = 16;
    localparam int CW   = 6;
    localparam int NV   = 6;
    localparam int SATN = (1 << CW) + 3;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [5:0][1:0] ids;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*FW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            wr_en;
    logic [FW-1:0]   data_in;
    logic            wr_ack = 1'b0;
    logic            overflow = 1'b0;
    logic            full;
    logic [1:0]      grant_id;
    logic            busy;
    logic [CW-1:0]   retry_cnt;

    logic            fifo_clr = 1'b0, fifo_fill = 1'b0, rd_req = 1'b0;
    logic            reject_next = 1'b0, full_hold = 1'b0;
    logic [15:0]     fifo_q[$];
    int              fifo_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .FIFO_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .wr_ack    (wr_ack),
        .overflow  (overflow),
        .full      (full),
        .grant_id  (grant_id),
        .busy      (busy),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered wr_ack/overflow, combinational full, optional forced reject.
    always @(posedge clk) begin
        wr_ack   <= 1'b0;
        overflow <= 1'b0;
        if (fifo_clr) begin
            fifo_q.delete();
        end else begin
            if (fifo_fill) begin
                while (fifo_q.size() < 8) fifo_q.push_back(16'hF000 + 16'(fifo_q.size()));
            end
            if (rd_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (wr_en) begin
                if (fifo_q.size() < 8 && !reject_next) begin
                    fifo_q.push_back(data_in);
                    wr_ack <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
        fifo_cnt = fifo_q.size();
    end

    assign full = (fifo_cnt >= 8) || full_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; fifo_clr = 1'b1;
        reject_next = 1'b0; full_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0; fifo_clr = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] m, input int n,
                                input int i0, input int i1, input int i2,
                                input int i3, input int i4);
        vec_t v;
        v.mask = m;
        v.n    = 3'(n);
        v.ids  = {2'd0, 2'(i4), 2'(i3), 2'(i2), 2'(i1), 2'(i0)};
        return v;
    endfunction

    function automatic logic [15:0] last_word();
        return (fifo_q.size() > 0) ? fifo_q[fifo_q.size()-1] : 16'hDEAD;
    endfunction

    vec_t        tab[NV];
    exp_t        sb[$];
    logic [15:0] exp_rd[$];
    exp_t        e;
    int          cnt[NR];
    int          got, cyc, k, seen_wr, seen_rdy;

    initial begin
        tab[0] = mk(4'b0001, 2, 0, 0, 0, 0, 0);
        tab[1] = mk(4'b1111, 5, 0, 1, 2, 3, 0);
        tab[2] = mk(4'b1010, 4, 1, 3, 1, 3, 0);
        tab[3] = mk(4'b0110, 3, 1, 2, 1, 0, 0);
        tab[4] = mk(4'b1000, 2, 3, 3, 0, 0, 0);
        tab[5] = mk(4'b1001, 3, 0, 3, 0, 0, 0);

        do_reset();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_retry_cnt", 32'(retry_cnt), 0);
        chk("rst_data_in", 32'(data_in), 0);

        // Latency: decision, wr_en, ack/ready, idle.
        req_data[15:0] = 16'hA5A5;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("lat_c1_wr_en", 32'(wr_en), 1);
        chk("lat_c1_data_in", 32'(data_in), 32'h0000A5A5);
        @(negedge clk);
        chk("lat_c2_wr_ack", 32'(wr_ack), 1);
        chk("lat_c2_req_ready", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);
        chk("lat_c3_busy", 32'(busy), 0);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("lat_rr_ptr_next_grant", 32'(grant_id), 1);
        cyc = 0;
        while (req_ready == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("lat_rr_ready", 32'(req_ready), 32'b0010);
        req_valid = '0;

        // Table-driven grant sequences from reset; scoreboard holds expected id/data.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                req_data[i*FW +: FW] = 16'(i);
                cnt[i] = 0;
            end
            sb.delete();
            exp_rd.delete();
            for (int j = 0; j < int'(tab[v].n); j++) begin
                e.id   = tab[v].ids[j];
                e.data = 16'(e.id) + 16'(cnt[e.id] * 16);
                cnt[e.id]++;
                sb.push_back(e);
                exp_rd.push_back(e.data);
            end
            req_valid = tab[v].mask;
            got = 0; cyc = 0;
            while (got < int'(tab[v].n) && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (req_ready != 0) begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_grant%0d", v, got), 32'(req_ready), 32'(4'b0001 << e.id));
                    chk($sformatf("v%0d_wdata%0d", v, got), 32'(last_word()), 32'(e.data));
                    for (int i = 0; i < NR; i++)
                        if (req_ready[i]) req_data[i*FW +: FW] = req_data[i*FW +: FW] + 16'h0010;
                    got++;
                    if (got == int'(tab[v].n)) req_valid = '0;
                end
            end
            req_valid = '0;
            chk($sformatf("v%0d_grants_done", v), 32'(got), 32'(tab[v].n));
            @(negedge clk);
            chk($sformatf("v%0d_readback_size", v), 32'(fifo_q.size()), 32'(exp_rd.size()));
            for (int j = 0; j < exp_rd.size() && j < fifo_q.size(); j++)
                chk($sformatf("v%0d_readback%0d", v, j), 32'(fifo_q[j]), 32'(exp_rd[j]));
        end

        // Full FIFO blocks grants until one read frees a slot.
        do_reset();
        @(negedge clk) fifo_fill = 1'b1;
        @(negedge clk) fifo_fill = 1'b0;
        req_data[2*FW +: FW] = 16'hC0DE;
        req_valid = 4'b0100;
        seen_wr = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (wr_en) seen_wr++; end
        chk("full_no_wr_en", 32'(seen_wr), 0);
        chk("full_not_busy", 32'(busy), 0);
        rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
        cyc = 0;
        while (req_ready == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("full_ready", 32'(req_ready), 32'b0100);
        chk("full_wdata", 32'(last_word()), 32'h0000C0DE);
        chk("full_retry_cnt", 32'(retry_cnt), 0);
        req_valid = '0;

        // Full drops at the decision, but the FIFO rejects; grant held until space returns.
        do_reset();
        @(negedge clk) fifo_fill = 1'b1;
        @(negedge clk) fifo_fill = 1'b0;
        req_data[2*FW +: FW] = 16'hBEEF;
        req_valid = 4'b0100;
        reject_next = 1'b1;
        rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
        cyc = 0;
        while (overflow == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("ovf_seen", 32'(overflow), 1);
        full_hold = 1'b1; reject_next = 1'b0;
        @(negedge clk);
        chk("ovf_retry_cnt", 32'(retry_cnt), 1);
        chk("ovf_busy", 32'(busy), 1);
        chk("ovf_grant_held", 32'(grant_id), 2);
        seen_wr = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (wr_en) seen_wr++; end
        chk("ovf_wait_no_wr_en", 32'(seen_wr), 0);
        full_hold = 1'b0;
        seen_wr = 0; seen_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_en) seen_wr++;
            if (req_ready == 4'b0100) begin seen_rdy++; req_valid = '0; end
        end
        chk("ovf_rewrite_count", 32'(seen_wr), 1);
        chk("ovf_ack_once", 32'(seen_rdy), 1);
        chk("ovf_rewrite_data", 32'(last_word()), 32'h0000BEEF);
        chk("ovf_retry_cnt_after", 32'(retry_cnt), 1);

        // Reset lands on CHECK with wr_ack high: no ready, state and pointer cleared.
        @(negedge clk) fifo_clr = 1'b1;
        @(negedge clk) fifo_clr = 1'b0;
        req_data[2*FW +: FW] = 16'h1234;
        req_valid = 4'b0100;
        cyc = 0;
        while (wr_ack == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rstchk_ack_seen", 32'(wr_ack), 1);
        rst = 1'b1;
        #1;
        chk("rstchk_ready_masked", 32'(req_ready), 0);
        @(negedge clk);
        chk("rstchk_busy", 32'(busy), 0);
        chk("rstchk_req_ready", 32'(req_ready), 0);
        chk("rstchk_retry_cnt", 32'(retry_cnt), 0);
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rstchk_rr_ptr_zero", 32'(grant_id), 0);
        cyc = 0;
        while (req_ready == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rstchk_ready0", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // Retry counter saturation under persistent rejection.
        do_reset();
        req_data[FW-1:0] = 16'h5555;
        req_valid = 4'b0001;
        reject_next = 1'b1;
        k = 0; cyc = 0; seen_rdy = 0;
        while (k < SATN && cyc < SATN * 3 + 40) begin
            @(negedge clk);
            cyc++;
            if (overflow) k++;
            if (req_ready != 0) seen_rdy++;
        end
        reject_next = 1'b0;
        chk("sat_rejections", 32'(k), 32'(SATN));
        chk("sat_no_ready", 32'(seen_rdy), 0);
        @(negedge clk);
        chk("sat_retry_cnt", 32'(retry_cnt), 32'((1 << CW) - 1));
        cyc = 0;
        while (req_ready == 0 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("sat_final_ready", 32'(req_ready), 32'b0001);
        chk("sat_retry_cnt_hold", 32'(retry_cnt), 32'((1 << CW) - 1));
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
